serial_sum_rx: RTL and testbench

Serial operand receiver for the adder datapath. It accepts two WIDTH-bit operands from an SPI-mode-0 style pin interface (sclk, cs_n, mosi) that is asynchronous to the design clock. It adds the two operands and presents the registered sum, carry and a one-cycle valid pulse. It sits between the dedicated input pins and the output pins of the top-level wrapper: bits come in on ui_in, the sum drives uo_out and the status bits drive uio_out.

---
 rtl/serial_sum_rx_if.sv | 51 +++++
 rtl/serial_sum_rx.sv | 197 +++++++++++++++++++
 tb/tb_serial_sum_rx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_sum_rx_if.sv
// ---------------------------------------------------------------------------
// serial_sum_rx_if
//
// Pin-level bundle for the serial operand receiver.
//   sclk_in   : serial clock from the pin, asynchronous to clk
//   cs_n_in   : frame select from the pin, active low, asynchronous
//   mosi_in   : serial data from the pin, MSB first, asynchronous
//   sum_out   : registered A+B, modulo 2^WIDTH
//   carry_out : carry out of A+B
//   valid_out : one-cycle pulse when sum_out/carry_out update
//   busy_out  : high while a frame is in progress
//   err_out   : sticky frame-abort flag
//
// Modports:
//   master : the pin driver side (drives the serial pins, observes results)
//   slave  : the receiver side (serial_sum_rx)
// ---------------------------------------------------------------------------
interface serial_sum_rx_if #(
    parameter int WIDTH = 8
);
    logic             sclk_in;
    logic             cs_n_in;
    logic             mosi_in;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;
    logic             valid_out;
    logic             busy_out;
    logic             err_out;

    modport master (
        output sclk_in,
        output cs_n_in,
        output mosi_in,
        input  sum_out,
        input  carry_out,
        input  valid_out,
        input  busy_out,
        input  err_out
    );

    modport slave (
        input  sclk_in,
        input  cs_n_in,
        input  mosi_in,
        output sum_out,
        output carry_out,
        output valid_out,
        output busy_out,
        output err_out
    );
endinterface

// File: rtl/serial_sum_rx.sv
// ---------------------------------------------------------------------------
// serial_sum_rx
//
// Receives two WIDTH-bit operands over an SPI-mode-0 style pin interface
// (sclk, cs_n, mosi; MSB first) that is asynchronous to clk, adds them and
// presents the registered sum and carry with a one-cycle valid pulse.
//
// Ports:
//   clk  : design clock, all logic on the rising edge
//   rst  : synchronous, active-high reset
//   pins : serial_sum_rx_if.slave bundle
//          inputs  sclk_in, cs_n_in, mosi_in
//          outputs sum_out, carry_out, valid_out, busy_out, err_out
//
// Frame: cs_n low, 2*WIDTH bits (operand A then operand B), cs_n high.
// Bits beyond 2*WIDTH are ignored. cs_n rising before the frame is complete
// aborts it and sets the sticky err_out, which clears when the next frame
// starts.
// ---------------------------------------------------------------------------
module serial_sum_rx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    serial_sum_rx_if.slave      pins
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT_A = 2'd1,
        ST_SHIFT_B = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Pin synchronizers. sclk and cs_n reset to their idle level (1) and mosi
    // to 0 so that releasing reset never looks like an edge or a frame start.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_n_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_d_q;

    logic sclk_s;
    logic cs_n_s;
    logic mosi_s;
    logic rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '1;
            cs_n_sync_q <= '1;
            mosi_sync_q <= '0;
            sclk_d_q    <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], pins.sclk_in};
            cs_n_sync_q <= {cs_n_sync_q[SYNC_STAGES-2:0], pins.cs_n_in};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], pins.mosi_in};
            sclk_d_q    <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_n_s = cs_n_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_d_q;

    // -----------------------------------------------------------------------
    // Datapath / FSM registers
    // -----------------------------------------------------------------------
    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] shift_q,  shift_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             carry_q,  carry_d;
    logic             valid_q,  valid_d;
    logic             busy_q,   busy_d;
    logic             err_q,    err_d;

    // Shift register contents including the bit arriving this cycle, and the
    // full-width add of operand A with that word.
    logic [WIDTH-1:0] word_next;
    logic             last_bit;
    logic [WIDTH:0]   add_full;

    assign word_next = {shift_q[WIDTH-2:0], mosi_s};
    assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
    assign add_full  = {1'b0, a_q} + {1'b0, word_next};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            a_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            a_q     <= a_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        a_d     = a_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        valid_d = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE: begin
                // Rises while idle are ignored; only a cs_n fall starts a frame.
                if (!cs_n_s) begin
                    state_d = ST_SHIFT_A;
                    cnt_d   = '0;
                    shift_d = '0;
                    err_d   = 1'b0;
                end
            end

            ST_SHIFT_A: begin
                // cs_n is checked first so a coincident rise is discarded.
                if (cs_n_s) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (rise) begin
                    if (last_bit) begin
                        a_d     = word_next;
                        cnt_d   = '0;
                        shift_d = '0;
                        state_d = ST_SHIFT_B;
                    end else begin
                        shift_d = word_next;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end

            ST_SHIFT_B: begin
                if (cs_n_s) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (rise) begin
                    if (last_bit) begin
                        sum_d   = add_full[WIDTH-1:0];
                        carry_d = add_full[WIDTH];
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        shift_d = word_next;
                        state_d = ST_DONE;
                    end else begin
                        shift_d = word_next;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end

            ST_DONE: begin
                // Surplus bits are dropped until the frame closes.
                if (cs_n_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign pins.sum_out   = sum_q;
    assign pins.carry_out = carry_q;
    assign pins.valid_out = valid_q;
    assign pins.busy_out  = busy_q;
    assign pins.err_out   = err_q;

endmodule

// File: tb/tb_serial_sum_rx.sv
module tb_serial_sum_rx;

    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   valid_cnt;
    int   valid_base;

    serial_sum_rx_if #(.WIDTH(WIDTH)) bus ();

    serial_sum_rx #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .pins (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts cycles with valid_out high, so a stretched pulse also shows up.
    always @(negedge clk) begin
        if (rst)
            valid_cnt <= 0;
        else if (bus.valid_out === 1'b1)
            valid_cnt <= valid_cnt + 1;
    end

    // Guard against a hung run.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, observed running required finished");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cs_fall();
        bus.sclk_in = 1'b0;
        bus.cs_n_in = 1'b0;
        tick(4);
    endtask

    // Sends the low n bits of word, MSB first; sclk period is 8 clk and mosi
    // changes only while sclk is low.
    task automatic send_bits(input logic [31:0] word, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.mosi_in = word[i];
            bus.sclk_in = 1'b0;
            tick(4);
            bus.sclk_in = 1'b1;
            tick(4);
        end
        bus.sclk_in = 1'b0;
        tick(4);
    endtask

    task automatic cs_rise();
        bus.cs_n_in = 1'b1;
        tick(8);
    endtask

    task automatic frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [8:0] exp_sum);
        valid_base = valid_cnt;
        cs_fall();
        send_bits({16'h0, a, b}, 16);
        cs_rise();
        chk({tag, "_valid"}, 32'(valid_cnt - valid_base), 32'd1);
        chk({tag, "_sum"},   32'(bus.sum_out), 32'(exp_sum[7:0]));
        chk({tag, "_carry"}, 32'(bus.carry_out), 32'(exp_sum[8]));
        chk({tag, "_err"},   32'(bus.err_out), 32'd0);
        $display("frame %s: A=0x%02h B=0x%02h sum=0x%02h carry=%0b",
                 tag, a, b, bus.sum_out, bus.carry_out);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        valid_cnt = 0;

        // Reset with random pins
        rst         = 1'b1;
        bus.sclk_in = 1'($urandom);
        bus.cs_n_in = 1'($urandom);
        bus.mosi_in = 1'($urandom);
        tick(3);
        chk("rst_sum",   32'(bus.sum_out), 32'd0);
        chk("rst_carry", 32'(bus.carry_out), 32'd0);
        chk("rst_valid", 32'(bus.valid_out), 32'd0);
        chk("rst_busy",  32'(bus.busy_out), 32'd0);
        chk("rst_err",   32'(bus.err_out), 32'd0);

        // Release with sclk toggling and cs_n high: nothing happens
        bus.cs_n_in = 1'b1;
        rst         = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.sclk_in = ~bus.sclk_in;
            bus.mosi_in = 1'($urandom);
            tick(4);
        end
        bus.sclk_in = 1'b0;
        tick(4);
        chk("idle_valid", 32'(valid_cnt), 32'd0);
        chk("idle_sum",   32'(bus.sum_out), 32'd0);
        chk("idle_busy",  32'(bus.busy_out), 32'd0);
        $display("reset and idle checked");

        // Basic frame with busy timing
        valid_base  = valid_cnt;
        bus.sclk_in = 1'b0;
        bus.cs_n_in = 1'b0;
        tick(1);
        chk("busy_early", 32'(bus.busy_out), 32'd0);
        tick(3);
        chk("busy_mid", 32'(bus.busy_out), 32'd1);
        send_bits({16'h0, 8'h12, 8'h34}, 16);
        chk("busy_done", 32'(bus.busy_out), 32'd1);
        bus.cs_n_in = 1'b1;
        tick(1);
        chk("busy_hold", 32'(bus.busy_out), 32'd1);
        tick(7);
        chk("busy_end",    32'(bus.busy_out), 32'd0);
        chk("basic_valid", 32'(valid_cnt - valid_base), 32'd1);
        chk("basic_sum",   32'(bus.sum_out), 32'h46);
        chk("basic_carry", 32'(bus.carry_out), 32'd0);
        chk("basic_err",   32'(bus.err_out), 32'd0);
        $display("frame basic: A=0x12 B=0x34 sum=0x%02h carry=%0b", bus.sum_out, bus.carry_out);

        // Abort after 11 bits
        valid_base = valid_cnt;
        cs_fall();
        send_bits(32'h0000_0123, 11);
        cs_rise();
        chk("abort_err",   32'(bus.err_out), 32'd1);
        chk("abort_valid", 32'(valid_cnt - valid_base), 32'd0);
        chk("abort_sum",   32'(bus.sum_out), 32'h46);
        chk("abort_busy",  32'(bus.busy_out), 32'd0);
        $display("abort: err=%0b sum=0x%02h", bus.err_out, bus.sum_out);

        // Next frame clears err once the frame starts
        valid_base = valid_cnt;
        cs_fall();
        chk("err_clear", 32'(bus.err_out), 32'd0);
        send_bits({16'h0, 8'h0F, 8'hF0}, 16);
        cs_rise();
        chk("recover_valid", 32'(valid_cnt - valid_base), 32'd1);
        chk("recover_sum",   32'(bus.sum_out), 32'hFF);
        chk("recover_carry", 32'(bus.carry_out), 32'd0);
        $display("frame recover: A=0x0F B=0xF0 sum=0x%02h", bus.sum_out);

        // Carry and wrap
        frame("ff01", 8'hFF, 8'h01, 9'h100);
        frame("8080", 8'h80, 8'h80, 9'h100);
        frame("0000", 8'h00, 8'h00, 9'h000);

        // Overrun: 16 frame bits followed by 4 junk bits
        valid_base = valid_cnt;
        cs_fall();
        send_bits(32'h0001_02F0 >> 4, 20);
        cs_rise();
        chk("ovr_valid", 32'(valid_cnt - valid_base), 32'd1);
        chk("ovr_sum",   32'(bus.sum_out), 32'h03);
        chk("ovr_carry", 32'(bus.carry_out), 32'd0);
        chk("ovr_err",   32'(bus.err_out), 32'd0);
        $display("frame overrun: sum=0x%02h err=%0b", bus.sum_out, bus.err_out);

        // Reset in the middle of operand A
        cs_fall();
        send_bits(32'h0000_0015, 5);
        rst         = 1'b1;
        bus.cs_n_in = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(8);
        chk("mrst_sum",  32'(bus.sum_out), 32'd0);
        chk("mrst_busy", 32'(bus.busy_out), 32'd0);
        chk("mrst_err",  32'(bus.err_out), 32'd0);
        chk("mrst_valid", 32'(valid_cnt), 32'd0);
        $display("mid-frame reset: sum=0x%02h busy=%0b", bus.sum_out, bus.busy_out);
        frame("post_rst", 8'h05, 8'h06, 9'h00B);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
